wb_frame_src: RTL and testbench

Synthesizable, parametrised Wishbone-style I/Q frame source that replays stored baseband samples into the OFDM receiver chain (`OFDM_RX_802_11`-style input port: `Q_CH`/`I_CH`, `CYC`/`STB`/`ACK`). It replaces the behavioural frame-feeding loop used in simulation with hardware usable on FPGA for loopback and hardware-in-the-loop testing. It supports:

- programmable frame length and frame count;
- an inter-frame gap;
- an optional wait for a downstream "frame consumed" indication, with timeout;
- a continuous loop mode.

---
 rtl/wb_frame_src.sv | 171 +++++++++++++++++
 tb/tb_wb_frame_src.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_frame_src.sv
// Wishbone-style I/Q frame source: replays frames from an internal sample memory
// with programmable length, count, inter-frame gap, optional done-wait and loop.
module wb_frame_src #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 12,
    parameter int unsigned GW = 16
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    input  logic            LD_WE_I,
    input  logic [AW-1:0]   LD_ADR_I,
    input  logic [2*DW-1:0] LD_DAT_I,
    input  logic            START_I,
    input  logic            STOP_I,
    input  logic [AW-1:0]   FRM_LEN_I,
    input  logic [7:0]      NUM_FRM_I,
    input  logic [GW-1:0]   GAP_I,
    input  logic [GW-1:0]   TMO_I,
    input  logic            WAIT_EN_I,
    input  logic            LOOP_I,
    input  logic            RX_DONE_I,
    output logic [DW-1:0]   Q_CH_O,
    output logic [DW-1:0]   I_CH_O,
    output logic            CYC_O,
    output logic            STB_O,
    input  logic            ACK_I,
    output logic            BUSY_O,
    output logic [7:0]      FRM_CNT_O,
    output logic            DONE_O,
    output logic            ERR_O
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_GAP} state_t;

    state_t          state_q;
    logic [2*DW-1:0] mem_q [0:(2**AW)-1];
    logic [AW-1:0]   ptr_q, scnt_q, len_q;
    logic [7:0]      nfrm_q, frm_cnt_q;
    logic [GW-1:0]   gap_q, tmo_q, cnt_q;
    logic            wait_en_q, loop_q, cyc_q, done_q, err_q;

    logic            start_ok, accept, last_smp, over_now, over_inc;
    logic [7:0]      frm_inc;
    logic [GW-1:0]   cnt_inc, gap_lim;

    always_ff @(posedge CLK_I) begin
        if (LD_WE_I && state_q == S_IDLE) begin
            mem_q[LD_ADR_I] <= LD_DAT_I;
        end
    end

    assign start_ok = START_I && (FRM_LEN_I != '0) && (NUM_FRM_I != '0) && (state_q == S_IDLE);
    assign accept   = cyc_q & ACK_I;
    assign last_smp = (scnt_q == len_q - 1'b1);
    assign frm_inc  = (frm_cnt_q == 8'hFF) ? frm_cnt_q : frm_cnt_q + 8'd1;
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign gap_lim  = (gap_q == '0) ? {{(GW-1){1'b0}}, 1'b1} : gap_q;
    assign over_now = (frm_cnt_q >= nfrm_q) && !loop_q;
    assign over_inc = (frm_inc >= nfrm_q) && !loop_q;

    // The gap counter is preloaded with 1 when the run ends, so a gap before
    // IDLE lasts G cycles while a gap before the next burst lasts G+1.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            scnt_q    <= '0;
            len_q     <= '0;
            nfrm_q    <= '0;
            frm_cnt_q <= '0;
            gap_q     <= '0;
            tmo_q     <= '0;
            cnt_q     <= '0;
            wait_en_q <= 1'b0;
            loop_q    <= 1'b0;
            cyc_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE && STOP_I) begin
                if (state_q == S_SEND && accept) begin
                    ptr_q  <= ptr_q + 1'b1;
                    scnt_q <= scnt_q + 1'b1;
                    if (last_smp) frm_cnt_q <= frm_inc;
                end
                state_q <= S_IDLE;
                cyc_q   <= 1'b0;
                done_q  <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_ok) begin
                            len_q     <= FRM_LEN_I;
                            nfrm_q    <= NUM_FRM_I;
                            gap_q     <= GAP_I;
                            tmo_q     <= TMO_I;
                            wait_en_q <= WAIT_EN_I;
                            loop_q    <= LOOP_I;
                            ptr_q     <= '0;
                            scnt_q    <= '0;
                            frm_cnt_q <= '0;
                            err_q     <= 1'b0;
                            cyc_q     <= 1'b1;
                            state_q   <= S_SEND;
                        end
                    end
                    S_SEND: begin
                        if (accept) begin
                            ptr_q  <= ptr_q + 1'b1;
                            scnt_q <= scnt_q + 1'b1;
                            if (last_smp) begin
                                frm_cnt_q <= frm_inc;
                                cyc_q     <= 1'b0;
                                if (wait_en_q) begin
                                    state_q <= S_WAIT;
                                    cnt_q   <= {{(GW-1){1'b0}}, 1'b1};
                                end else begin
                                    state_q <= S_GAP;
                                    cnt_q   <= {{(GW-1){1'b0}}, over_inc};
                                end
                            end
                        end
                    end
                    S_WAIT: begin
                        if (RX_DONE_I) begin
                            state_q <= S_GAP;
                            cnt_q   <= {{(GW-1){1'b0}}, over_now};
                        end else if (tmo_q != '0 && cnt_q >= tmo_q) begin
                            err_q   <= 1'b1;
                            state_q <= S_GAP;
                            cnt_q   <= {{(GW-1){1'b0}}, over_now};
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    S_GAP: begin
                        if (cnt_q >= gap_lim) begin
                            if (frm_cnt_q < nfrm_q) begin
                                scnt_q  <= '0;
                                cyc_q   <= 1'b1;
                                state_q <= S_SEND;
                            end else if (loop_q) begin
                                scnt_q    <= '0;
                                ptr_q     <= '0;
                                frm_cnt_q <= '0;
                                cyc_q     <= 1'b1;
                                state_q   <= S_SEND;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign {Q_CH_O, I_CH_O} = cyc_q ? mem_q[ptr_q] : '0;
    assign CYC_O     = cyc_q;
    assign STB_O     = cyc_q;
    assign BUSY_O    = (state_q != S_IDLE);
    assign FRM_CNT_O = frm_cnt_q;
    assign DONE_O    = done_q;
    assign ERR_O     = err_q;

endmodule

// File: tb/tb_wb_frame_src.sv
// Directed bench for wb_frame_src: table of frame runs plus hand-written
// sequences for done-wait/timeout, loop/stop, illegal start and async reset.
module tb_wb_frame_src;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 12;
    localparam int unsigned GW = 16;

    logic            CLK_I = 1'b0;
    logic            RST_I;
    logic            LD_WE_I;
    logic [AW-1:0]   LD_ADR_I;
    logic [2*DW-1:0] LD_DAT_I;
    logic            START_I, STOP_I;
    logic [AW-1:0]   FRM_LEN_I;
    logic [7:0]      NUM_FRM_I;
    logic [GW-1:0]   GAP_I, TMO_I;
    logic            WAIT_EN_I, LOOP_I, RX_DONE_I;
    logic [DW-1:0]   Q_CH_O, I_CH_O;
    logic            CYC_O, STB_O, ACK_I, BUSY_O, DONE_O, ERR_O;
    logic [7:0]      FRM_CNT_O;

    int nerr = 0;
    int nchk = 0;

    wb_frame_src #(.DW(DW), .AW(AW), .GW(GW)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .LD_WE_I(LD_WE_I), .LD_ADR_I(LD_ADR_I), .LD_DAT_I(LD_DAT_I),
        .START_I(START_I), .STOP_I(STOP_I),
        .FRM_LEN_I(FRM_LEN_I), .NUM_FRM_I(NUM_FRM_I),
        .GAP_I(GAP_I), .TMO_I(TMO_I),
        .WAIT_EN_I(WAIT_EN_I), .LOOP_I(LOOP_I), .RX_DONE_I(RX_DONE_I),
        .Q_CH_O(Q_CH_O), .I_CH_O(I_CH_O),
        .CYC_O(CYC_O), .STB_O(STB_O), .ACK_I(ACK_I),
        .BUSY_O(BUSY_O), .FRM_CNT_O(FRM_CNT_O),
        .DONE_O(DONE_O), .ERR_O(ERR_O)
    );

    always #5 CLK_I = ~CLK_I;

    typedef struct {
        int len;
        int nfrm;
        int gap;
        bit tog;
        int exp_acc;
        int exp_done;
        int exp_low;
    } vec_t;

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [2*DW-1:0] exp_word(input int a);
        logic [DW-1:0] x;
        x = a[DW-1:0];
        return {x, ~x};
    endfunction

    task automatic run_vec(input vec_t v);
        int acc, data_bad, done_c, runlen, nruns, run_bad;
        logic            held;
        logic [2*DW-1:0] held_data, cur;
        acc = 0; data_bad = 0; done_c = 0; runlen = 0; nruns = 0; run_bad = 0;
        held = 1'b0; held_data = '0;
        FRM_LEN_I = AW'(v.len); NUM_FRM_I = 8'(v.nfrm); GAP_I = GW'(v.gap);
        TMO_I = '0; WAIT_EN_I = 1'b0; LOOP_I = 1'b0; ACK_I = 1'b0; START_I = 1'b1;
        tick();
        START_I = 1'b0;
        chk("start_busy", BUSY_O, 1);
        chk("start_stb", STB_O, 1);
        for (int c = 1; c <= 2000 && done_c == 0; c++) begin
            ACK_I = v.tog ? ((c % 2) == 1) : 1'b1;
            cur = {Q_CH_O, I_CH_O};
            if (STB_O) begin
                if (runlen != 0) begin
                    nruns++;
                    if (runlen != v.exp_low) run_bad++;
                    runlen = 0;
                end
                if (cur != exp_word(acc)) data_bad++;
                if (held && cur != held_data) data_bad++;
                if (ACK_I) acc++;
                held = !ACK_I;
                held_data = cur;
            end else if (acc != 0) begin
                runlen++;
            end
            tick();
            if (DONE_O) done_c = c;
        end
        ACK_I = 1'b0;
        chk("accepts", acc, v.exp_acc);
        chk("done_cycle", done_c, v.exp_done);
        chk("frm_cnt_end", FRM_CNT_O, v.nfrm);
        chk("busy_end", BUSY_O, 0);
        chk("data_order", data_bad, 0);
        chk("gap_count", nruns, v.nfrm - 1);
        chk("gap_len", run_bad, 0);
        tick();
        chk("done_pulse_1cyc", DONE_O, 0);
    endtask

    initial begin
        vec_t vecs[5];
        vec_t vchk;
        int   acc, data_bad;

        // {len, nfrm, gap, ack toggle, accepts, DONE cycle after START edge, low cycles between bursts}
        vecs[0] = '{80, 1, 0, 1'b0, 80,  81, 2};
        vecs[1] = '{80, 1, 0, 1'b1, 80, 160, 2};
        vecs[2] = '{16, 3, 5, 1'b0, 48,  65, 6};
        vecs[3] = '{ 5, 2, 0, 1'b0, 10,  13, 2};
        vecs[4] = '{ 1, 4, 2, 1'b0,  4,  15, 3};

        RST_I = 1'b0; LD_WE_I = 1'b0; LD_ADR_I = '0; LD_DAT_I = '0;
        START_I = 1'b0; STOP_I = 1'b0; FRM_LEN_I = '0; NUM_FRM_I = '0;
        GAP_I = '0; TMO_I = '0; WAIT_EN_I = 1'b0; LOOP_I = 1'b0;
        RX_DONE_I = 1'b0; ACK_I = 1'b0;
        tick(); tick();
        chk("rst_cyc", CYC_O, 0);
        chk("rst_busy", BUSY_O, 0);
        chk("rst_outs", {DONE_O, ERR_O, FRM_CNT_O, Q_CH_O, I_CH_O}, 0);
        RST_I = 1'b1;
        tick();

        for (int i = 0; i < 256; i++) begin
            LD_WE_I = 1'b1; LD_ADR_I = AW'(i); LD_DAT_I = exp_word(i);
            tick();
        end
        LD_WE_I = 1'b0;

        for (int unsigned k = 0; k < 5; k++) run_vec(vecs[k]);

        // Done-wait: frame 1 released by RX_DONE, frame 2 times out (pulse at its last accept ignored)
        FRM_LEN_I = 4; NUM_FRM_I = 2; GAP_I = 0; TMO_I = 10; WAIT_EN_I = 1'b1;
        LOOP_I = 1'b0; ACK_I = 1'b1; START_I = 1'b1;
        tick();
        START_I = 1'b0; WAIT_EN_I = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            RX_DONE_I = (c == 8 || c == 14);
            tick();
            if (c == 3)  chk("w_stb_f1", STB_O, 1);
            if (c == 4)  chk("w_cyc_low", CYC_O, 0);
            if (c == 9)  chk("w_gap_low", STB_O, 0);
            if (c == 10) begin
                chk("w_f2_stb", STB_O, 1);
                chk("w_f2_data", Q_CH_O, 4);
                chk("w_no_err", ERR_O, 0);
            end
            if (c == 23) begin
                chk("w_err_early", ERR_O, 0);
                chk("w_busy", BUSY_O, 1);
            end
            if (c == 24) chk("w_err_set", ERR_O, 1);
            if (c == 25) begin
                chk("w_done", DONE_O, 1);
                chk("w_busy_end", BUSY_O, 0);
                chk("w_frm", FRM_CNT_O, 2);
            end
            if (c == 26) begin
                chk("w_done_pulse", DONE_O, 0);
                chk("w_err_sticky", ERR_O, 1);
            end
        end
        RX_DONE_I = 1'b0;

        // Loop mode, then STOP mid-burst of the second pass (coincident accept)
        FRM_LEN_I = 8; NUM_FRM_I = 2; GAP_I = 0; TMO_I = 0; LOOP_I = 1'b1;
        ACK_I = 1'b1; START_I = 1'b1;
        tick();
        START_I = 1'b0; LOOP_I = 1'b0;
        chk("l_err_cleared", ERR_O, 0);
        acc = 0; data_bad = 0;
        for (int c = 1; c <= 33; c++) begin
            STOP_I = (c == 33);
            if (STB_O && ACK_I) begin
                if ({Q_CH_O, I_CH_O} != exp_word(acc % 16)) data_bad++;
                acc++;
            end
            tick();
        end
        STOP_I = 1'b0; ACK_I = 1'b0;
        chk("l_data", data_bad, 0);
        chk("l_accepts", acc, 27);
        chk("l_stop_cyc", CYC_O, 0);
        chk("l_stop_done", DONE_O, 1);
        chk("l_stop_busy", BUSY_O, 0);
        chk("l_frm", FRM_CNT_O, 1);
        tick();
        chk("l_done_pulse", DONE_O, 0);

        // Illegal starts
        FRM_LEN_I = 0; NUM_FRM_I = 1; START_I = 1'b1;
        tick();
        chk("ill_len0", BUSY_O, 0);
        FRM_LEN_I = 8; NUM_FRM_I = 0;
        tick();
        chk("ill_num0", BUSY_O, 0);
        START_I = 1'b0;

        // Write while busy is dropped; async reset mid-burst
        FRM_LEN_I = 4; NUM_FRM_I = 3; GAP_I = 0; ACK_I = 1'b1; START_I = 1'b1;
        tick();
        START_I = 1'b0;
        LD_WE_I = 1'b1; LD_ADR_I = 5; LD_DAT_I = 32'hDEAD_BEEF;
        tick();
        LD_WE_I = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        chk("r_pre_stb", STB_O, 1);
        chk("r_pre_frm", FRM_CNT_O, 1);
        #2 RST_I = 1'b0;
        #1;
        chk("r_async_cyc", {CYC_O, STB_O}, 0);
        chk("r_async_busy", BUSY_O, 0);
        chk("r_async_outs", {DONE_O, ERR_O, FRM_CNT_O, Q_CH_O, I_CH_O}, 0);
        #2 RST_I = 1'b1;
        ACK_I = 1'b0;
        tick();
        vchk = '{8, 1, 0, 1'b0, 8, 9, 2};
        run_vec(vchk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
